// File: rtl/gate_check_pkg.sv
// Shared types for the gate truth-table checker: function encoding, expected
// tables, FSM state and the registered result bundle.
package gate_check_pkg;

  typedef enum logic [2:0] {
    FUNC_AND   = 3'd0,
    FUNC_OR    = 3'd1,
    FUNC_NAND  = 3'd2,
    FUNC_NOR   = 3'd3,
    FUNC_XOR   = 3'd4,
    FUNC_XNOR  = 3'd5,
    FUNC_BUF_A = 3'd6,
    FUNC_NOT_A = 3'd7
  } func_e;

  // bit i = expected y for vector i, where {a,b} = {i[1],i[0]}
  localparam logic [3:0] TT_AND   = 4'b1000;
  localparam logic [3:0] TT_OR    = 4'b1110;
  localparam logic [3:0] TT_NAND  = 4'b0111;
  localparam logic [3:0] TT_NOR   = 4'b0001;
  localparam logic [3:0] TT_XOR   = 4'b0110;
  localparam logic [3:0] TT_XNOR  = 4'b1001;
  localparam logic [3:0] TT_BUF_A = 4'b1100;
  localparam logic [3:0] TT_NOT_A = 4'b0011;

  function automatic logic [3:0] expected_table(input func_e f);
    case (f)
      FUNC_AND:   return TT_AND;
      FUNC_OR:    return TT_OR;
      FUNC_NAND:  return TT_NAND;
      FUNC_NOR:   return TT_NOR;
      FUNC_XOR:   return TT_XOR;
      FUNC_XNOR:  return TT_XNOR;
      FUNC_BUF_A: return TT_BUF_A;
      default:    return TT_NOT_A;
    endcase
  endfunction

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_e;

  typedef struct packed {
    logic       pass;
    logic [3:0] fail_mask;
    logic [3:0] observed;
  } result_t;

endpackage

// File: rtl/gate_settle_timer.sv
// Loadable down-counter holding each vector for SETTLE_CYCLES extra cycles;
// zero marks the sampling cycle.
module gate_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYCLES);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= LOAD_VAL;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Drives the four {a,b} vectors into a two-input gate, samples y after a settle
// delay and grades it against a selected truth table. GATE_CHECK_ERRCNT_EN adds err_count.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] func_sel,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [3:0] observed
`ifdef GATE_CHECK_ERRCNT_EN
  ,output logic [7:0] err_count
`endif
);

  state_e     state, state_nxt;
  func_e      func_q;
  logic [1:0] idx;
  logic [2:0] obs_acc;
  result_t    res_q;
  logic       t_load, t_en, t_zero;
  logic       accept, sample, last;
  logic [3:0] obs_full, fm_full;

  gate_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (t_load),
    .en    (t_en),
    .zero  (t_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    t_load    = 1'b0;
    t_en      = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        state_nxt = ST_APPLY;
        t_load    = 1'b1;
      end
      ST_APPLY: begin
        if (t_zero) begin
          if (idx == 2'd3) state_nxt = ST_IDLE;
          else             t_load    = 1'b1;
        end else begin
          t_en = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept   = (state == ST_IDLE) && start;
  assign sample   = (state == ST_APPLY) && t_zero;
  assign last     = sample && (idx == 2'd3);
  // Last sample bypasses obs_acc so all result fields update on the same edge
  assign obs_full = {dut_y, obs_acc};
  assign fm_full  = obs_full ^ expected_table(func_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      func_q  <= FUNC_AND;
      idx     <= 2'd0;
      obs_acc <= '0;
      dut_a   <= 1'b0;
      dut_b   <= 1'b0;
      done    <= 1'b0;
      res_q   <= '0;
`ifdef GATE_CHECK_ERRCNT_EN
      err_count <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        func_q         <= func_e'(func_sel);
        idx            <= 2'd0;
        {dut_a, dut_b} <= 2'b00;
      end
      if (sample && !last) begin
        obs_acc[idx]   <= dut_y;
        idx            <= idx + 2'd1;
        {dut_a, dut_b} <= idx + 2'd1;
      end
      if (last) begin
        {dut_a, dut_b}  <= 2'b00;
        res_q.observed  <= obs_full;
        res_q.fail_mask <= fm_full;
        res_q.pass      <= (fm_full == 4'd0);
        done            <= 1'b1;
`ifdef GATE_CHECK_ERRCNT_EN
        if (fm_full != 4'd0 && err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
      end
    end
  end

  assign busy      = (state == ST_APPLY);
  assign pass      = res_q.pass;
  assign fail_mask = res_q.fail_mask;
  assign observed  = res_q.observed;

endmodule
